alu_exec_ctrl: RTL and testbench

Execute-stage controller wrapped around alu_128bit. Holds an NREGS x DWIDTH register file and accepts one ALU instruction at a time over a valid/ready handshake. Reads the operands, drives the ALU's op1/op2/opsel/mode pins, captures the result and the four flags, and writes the result back. Sits directly upstream of alu_128bit, which is purely combinational, and also consumes its outputs.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_exec_ctrl_if.sv | 24 ++
 rtl/alu_128bit.sv | 74 +++++++
 rtl/alu_regfile.sv | 47 ++++
 rtl/alu_exec_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_exec_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU controller:
// opcodes, FSM states, flag indices and opcode legality.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD    = 4'h0,
    SUBWB  = 4'h1,
    MOV    = 4'h2,
    SUB    = 4'h3,
    INC    = 4'h4,
    DEC    = 4'h5,
    ADDINC = 4'h6,
    AND    = 4'h8,
    OR     = 4'h9,
    XOR    = 4'hA,
    NOT    = 4'hB,
    MOVE   = 4'hC,
    SHL    = 4'hD
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } exec_state_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_O = 2;
  localparam int FLAG_S = 3;

  // 4'h7, 4'hE and 4'hF have no ALU function
  function automatic logic is_legal_op(alu_op_e op);
    logic [3:0] v;
    v = op;
    return !(v inside {4'h7, 4'hE, 4'hF});
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction issue channel: valid/ready plus op/rd/rs1/rs2.
// master = issuer, slave = alu_exec_ctrl.
interface alu_exec_ctrl_if #(
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;

  modport master (
    output in_valid, in_op, in_rd,
    output in_rs1, in_rs2,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd,
    input  in_rs1, in_rs2,
    output in_ready
  );
endinterface

// File: rtl/alu_128bit.sv
// Combinational ALU: mode 0 arithmetic, mode 1 logic/shift.
// Ports: op1, op2, opsel, mode in; result, c/z/o/s out.
module alu_128bit #(
  parameter int DWIDTH = 128
) (
  input  logic [DWIDTH-1:0] op1,
  input  logic [DWIDTH-1:0] op2,
  input  logic [2:0]        opsel,
  input  logic              mode,
  output logic [DWIDTH-1:0] result,
  output logic              c,
  output logic              z,
  output logic              o,
  output logic              s
);

  localparam int MSB = DWIDTH - 1;

  logic [DWIDTH-1:0] bb;
  logic              cin;
  logic              arith;
  logic [DWIDTH:0]   sum;

  // every arithmetic op is op1 + bb + cin
  always_comb begin
    bb    = '0;
    cin   = 1'b0;
    arith = !mode;
    if (!mode) begin
      case (opsel)
        3'd0: bb = op2;
        3'd1: bb = ~op2;
        3'd2: bb = '0;
        3'd3: begin bb = ~op2; cin = 1'b1; end
        3'd4: cin = 1'b1;
        3'd5: bb = '1;
        3'd6: begin bb = op2; cin = 1'b1; end
        default: arith = 1'b0;
      endcase
    end
  end

  assign sum = {1'b0, op1} + {1'b0, bb} +
               {{DWIDTH{1'b0}}, cin};

  always_comb begin
    result = '0;
    c      = 1'b0;
    o      = 1'b0;
    if (arith) begin
      result = sum[MSB:0];
      c      = sum[DWIDTH];
      o      = (op1[MSB] == bb[MSB]) &&
               (sum[MSB] != op1[MSB]);
    end else if (mode) begin
      case (opsel)
        3'd0: result = op1 & op2;
        3'd1: result = op1 | op2;
        3'd2: result = op1 ^ op2;
        3'd3: result = ~op1;
        3'd4: result = op2;
        3'd5: begin
          result = {op1[MSB-1:0], 1'b0};
          c      = op1[MSB];
        end
        default: result = '0;
      endcase
    end
  end

  assign z = (result == '0);
  assign s = result[MSB];

endmodule

// File: rtl/alu_regfile.sv
// NREGS x DWIDTH register file: two async read ports, a debug
// read port, WB and ld write ports (WB wins on same address).
module alu_regfile #(
  parameter  int DWIDTH = 128,
  parameter  int NREGS  = 8,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rd1_addr,
  output logic [DWIDTH-1:0] rd1_data,
  input  logic [AW-1:0]     rd2_addr,
  output logic [DWIDTH-1:0] rd2_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DWIDTH-1:0] dbg_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DWIDTH-1:0] wb_data,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DWIDTH-1:0] ld_data
);

  logic [DWIDTH-1:0] regs [NREGS];
  logic              ld_hit;

  assign rd1_data = regs[rd1_addr];
  assign rd2_data = regs[rd2_addr];
  assign dbg_data = regs[dbg_addr];

  // ld is dropped when WB targets the same register
  assign ld_hit = ld_en &&
                  !(wb_en && wb_addr == ld_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      if (ld_hit)
        regs[ld_addr] <= ld_data;
      if (wb_en)
        regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller around alu_128bit: issue, drive ALU,
// capture result/flags, write back. Ports: clk, rst_n, in_if,
// ld_*, alu_*, done_*, flags, dbg_addr/dbg_data.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter  int DWIDTH = 128,
  parameter  int NREGS  = 8,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_exec_ctrl_if.slave    in_if,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DWIDTH-1:0] ld_data,
  output logic [DWIDTH-1:0] alu_op1,
  output logic [DWIDTH-1:0] alu_op2,
  output logic [2:0]        alu_opsel,
  output logic              alu_mode,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_o,
  input  logic              alu_s,
  output logic              done_valid,
  output logic              done_err,
  output logic [AW-1:0]     done_rd,
  output logic [3:0]        flags,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DWIDTH-1:0] dbg_data
);

  exec_state_e       state_q;
  exec_state_e       state_d;
  logic [3:0]        op_q;
  logic [AW-1:0]     rd_q;
  logic [DWIDTH-1:0] op1_q;
  logic [DWIDTH-1:0] op2_q;
  logic [DWIDTH-1:0] res_q;
  logic [3:0]        flag_q;
  logic [3:0]        flags_q;
  logic [DWIDTH-1:0] rs1_data;
  logic [DWIDTH-1:0] rs2_data;
  logic              accept;
  logic              legal;
  logic              wb_en;

  assign in_if.in_ready = (state_q == IDLE) && rst_n;
  assign accept = in_if.in_valid && in_if.in_ready;
  assign legal  = is_legal_op(alu_op_e'(op_q));
  assign wb_en  = (state_q == WB) && legal && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operands come from pre-edge register contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= 4'h0;
      rd_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      flag_q  <= 4'h0;
      flags_q <= 4'h0;
    end else begin
      if (accept) begin
        op_q  <= in_if.in_op;
        rd_q  <= in_if.in_rd;
        op1_q <= rs1_data;
        op2_q <= rs2_data;
      end
      if (state_q == EXEC) begin
        res_q          <= alu_result;
        flag_q[FLAG_C] <= alu_c;
        flag_q[FLAG_Z] <= alu_z;
        flag_q[FLAG_O] <= alu_o;
        flag_q[FLAG_S] <= alu_s;
      end
      if (wb_en)
        flags_q <= flag_q;
    end
  end

  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign alu_opsel = op_q[2:0];
  assign alu_mode  = op_q[3];

  assign done_valid = (state_q == WB) && rst_n;
  assign done_err   = done_valid && !legal;
  assign done_rd    = rd_q;
  assign flags      = flags_q;

  alu_regfile #(
    .DWIDTH (DWIDTH),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd1_addr (in_if.in_rs1),
    .rd1_data (rs1_data),
    .rd2_addr (in_if.in_rs2),
    .rd2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wb_en    (wb_en),
    .wb_addr  (rd_q),
    .wb_data  (res_q),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl + alu_128bit:
// opcode vector table plus reset/collision/abort sequences.
module tb_alu_exec_ctrl;

  localparam int DW = 128;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] alu_op1;
  logic [DW-1:0] alu_op2;
  logic [2:0]    alu_opsel;
  logic          alu_mode;
  logic [DW-1:0] alu_result;
  logic          alu_c, alu_z, alu_o, alu_s;
  logic          done_valid;
  logic          done_err;
  logic [AW-1:0] done_rd;
  logic [3:0]    flags;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  int total = 0;
  int bad   = 0;

  alu_exec_ctrl_if #(.AW(AW)) in_if ();

  alu_exec_ctrl #(.DWIDTH(DW), .NREGS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (in_if),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_opsel  (alu_opsel),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .alu_o      (alu_o),
    .alu_s      (alu_s),
    .done_valid (done_valid),
    .done_err   (done_err),
    .done_rd    (done_rd),
    .flags      (flags),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  alu_128bit #(.DWIDTH(DW)) u_alu (
    .op1    (alu_op1),
    .op2    (alu_op2),
    .opsel  (alu_opsel),
    .mode   (alu_mode),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z),
    .o      (alu_o),
    .s      (alu_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: no finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic [3:0]    fl;
    logic          err;
  } vec_t;

  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] SENT = 128'hDEAD;

  vec_t vecs [18];

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic rd_reg(input logic [AW-1:0] a,
                        output logic [DW-1:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic chk_reg(input string nm,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] exp);
    logic [DW-1:0] v;
    rd_reg(a, v);
    chk(nm, v, exp);
  endtask

  task automatic preload(input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // starts and ends on a negedge; optional ld during WB
  task automatic issue(input logic [3:0] op,
                       input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2,
                       input logic [DW-1:0] xa,
                       input logic [DW-1:0] xb,
                       input logic xerr,
                       input logic wb_ld,
                       input logic [AW-1:0] la,
                       input logic [DW-1:0] ld);
    int n;
    n = 0;
    while (!in_if.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {127'd0, in_if.in_ready}, 1);
    in_if.in_valid = 1'b1;
    in_if.in_op    = op;
    in_if.in_rd    = rd;
    in_if.in_rs1   = rs1;
    in_if.in_rs2   = rs2;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    chk("ex_ready", {127'd0, in_if.in_ready}, 0);
    chk("ex_op1", alu_op1, xa);
    chk("ex_op2", alu_op2, xb);
    chk("ex_opsel", {125'd0, alu_opsel},
        {125'd0, op[2:0]});
    chk("ex_mode", {127'd0, alu_mode}, {127'd0, op[3]});
    chk("ex_done", {127'd0, done_valid}, 0);
    @(negedge clk);
    if (wb_ld) begin
      ld_en   = 1'b1;
      ld_addr = la;
      ld_data = ld;
    end
    chk("wb_ready", {127'd0, in_if.in_ready}, 0);
    chk("wb_done", {127'd0, done_valid}, 1);
    chk("wb_err", {127'd0, done_err}, {127'd0, xerr});
    chk("wb_rd", {125'd0, done_rd}, {125'd0, rd});
    @(negedge clk);
    ld_en = 1'b0;
    chk("post_done", {127'd0, done_valid}, 0);
    chk("post_ready", {127'd0, in_if.in_ready}, 1);
  endtask

  initial begin
    vecs[0]  = '{4'h0, 5, 3 + 2, 8, 4'b0000, 0};
    vecs[0].b = 5;
    vecs[0].a = 3;
    vecs[1]  = '{4'h0, ONES, 1, 0, 4'b0011, 0};
    vecs[2]  = '{4'h3, 5, 3, 2, 4'b0001, 0};
    vecs[3]  = '{4'h3, 3, 5, ONES - 1, 4'b1000, 0};
    vecs[4]  = '{4'h1, 5, 3, 1, 4'b0001, 0};
    vecs[5]  = '{4'h6, 1, 2, 4, 4'b0000, 0};
    vecs[6]  = '{4'h4, 7, 9, 8, 4'b0000, 0};
    vecs[7]  = '{4'h5, 0, 9, ONES, 4'b1000, 0};
    vecs[8]  = '{4'h7, 1, 2, SENT, 4'b1000, 1};
    vecs[9]  = '{4'h8, 'hF0, 'h3C, 'h30, 4'b0000, 0};
    vecs[10] = '{4'h9, 'hF0, 'h0F, 'hFF, 4'b0000, 0};
    vecs[11] = '{4'hA, 'hFF, 'hFF, 0, 4'b0010, 0};
    vecs[12] = '{4'hB, 0, 7, ONES, 4'b1000, 0};
    vecs[13] = '{4'hC, 3, 'h56, 'h56, 4'b0000, 0};
    vecs[14] = '{4'h2, 'h1234, 5, 'h1234, 4'b0000, 0};
    vecs[15] = '{4'hD, {1'b1, 126'd0, 1'b1}, 0, 2,
                 4'b0001, 0};
    vecs[16] = '{4'hE, 1, 2, SENT, 4'b0001, 1};
    vecs[17] = '{4'hF, 1, 2, SENT, 4'b0001, 1};

    rst_n          = 1'b0;
    in_if.in_valid = 1'b1;
    in_if.in_op    = 4'h0;
    in_if.in_rd    = 3'd1;
    in_if.in_rs1   = 3'd0;
    in_if.in_rs2   = 3'd0;
    ld_en          = 1'b0;
    ld_addr        = '0;
    ld_data        = '0;
    dbg_addr       = '0;

    // reset held two cycles with a pending offer
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {127'd0, in_if.in_ready}, 0);
    chk("rst_flags", {124'd0, flags}, 0);
    chk("rst_done", {127'd0, done_valid}, 0);
    chk("rst_rd", {125'd0, done_rd}, 0);
    for (int i = 0; i < 8; i++)
      chk_reg("rst_reg", AW'(i), 0);
    in_if.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", {127'd0, in_if.in_ready}, 1);
    chk("rel_done", {127'd0, done_valid}, 0);

    // opcode table: r1=a, r2=b, r3=sentinel, rd=3
    for (int i = 0; i < 18; i++) begin
      preload(3'd1, vecs[i].a);
      preload(3'd2, vecs[i].b);
      preload(3'd3, SENT);
      issue(vecs[i].op, 3'd3, 3'd1, 3'd2,
            vecs[i].a, vecs[i].b, vecs[i].err,
            1'b0, 3'd0, 0);
      chk_reg($sformatf("vec%0d_res", i), 3'd3,
              vecs[i].res);
      chk($sformatf("vec%0d_flags", i),
          {124'd0, flags}, {124'd0, vecs[i].fl});
    end

    // carry/zero wrap, then illegal op keeps state
    preload(3'd1, ONES);
    preload(3'd2, 1);
    issue(4'h0, 3'd4, 3'd1, 3'd2, ONES, 1, 1'b0,
          1'b0, 3'd0, 0);
    chk_reg("wrap_r4", 3'd4, 0);
    chk("wrap_flags", {124'd0, flags}, 4'b0011);
    preload(3'd5, 'hAA);
    issue(4'hF, 3'd5, 3'd1, 3'd2, ONES, 1, 1'b1,
          1'b0, 3'd0, 0);
    chk_reg("ill_r5", 3'd5, 'hAA);
    chk("ill_flags", {124'd0, flags}, 4'b0011);

    // rd aliases rs1
    preload(3'd1, 'h11);
    preload(3'd2, 'h22);
    issue(4'h0, 3'd1, 3'd1, 3'd2, 'h11, 'h22, 1'b0,
          1'b0, 3'd0, 0);
    chk_reg("alias_r1", 3'd1, 'h33);

    // same-address ld loses to writeback
    preload(3'd1, 'h10);
    preload(3'd2, 'h20);
    issue(4'h0, 3'd2, 3'd1, 3'd2, 'h10, 'h20, 1'b0,
          1'b1, 3'd2, 'h55);
    chk_reg("coll_r2", 3'd2, 'h30);
    // different address: both land
    issue(4'h0, 3'd2, 3'd1, 3'd2, 'h10, 'h30, 1'b0,
          1'b1, 3'd6, 'h55);
    chk_reg("split_r2", 3'd2, 'h40);
    chk_reg("split_r6", 3'd6, 'h55);

    // reset during EXEC aborts the instruction
    preload(3'd7, 'h99);
    chk_reg("pre_r7", 3'd7, 'h99);
    in_if.in_valid = 1'b1;
    in_if.in_op    = 4'hA;
    in_if.in_rd    = 3'd7;
    in_if.in_rs1   = 3'd1;
    in_if.in_rs2   = 3'd2;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    chk("ab_exec_op1", alu_op1, 'h10);
    rst_n = 1'b0;
    #1;
    chk("ab_done0", {127'd0, done_valid}, 0);
    @(negedge clk);
    chk("ab_done1", {127'd0, done_valid}, 0);
    chk("ab_ready", {127'd0, in_if.in_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ab_done2", {127'd0, done_valid}, 0);
    chk("ab_idle", {127'd0, in_if.in_ready}, 1);
    chk_reg("ab_r7", 3'd7, 0);
    chk("ab_flags", {124'd0, flags}, 0);

    // controller still usable after abort
    preload(3'd1, 2);
    preload(3'd2, 2);
    issue(4'h0, 3'd0, 3'd1, 3'd2, 2, 2, 1'b0,
          1'b0, 3'd0, 0);
    chk_reg("after_r0", 3'd0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
